// File: rtl/wb_burst_master.sv
// wb_burst_master
//   Wishbone B3 burst traffic/self-check engine. For each accepted command it
//   writes an incrementing pattern (seed, seed+1, ...) as one incrementing
//   burst, idles for one cycle, then reads the same region back as one burst
//   and compares every returned word against the pattern.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   sdr_init_done        commands are accepted only while high
//   cmd_valid/cmd_ready  command handshake (see below)
//   cmd_addr             byte start address, low DW/8-alignment bits ignored
//   cmd_len              beat count, 0 encodes 2**BL
//   cmd_seed             first pattern word
//   done                 one-cycle pulse when a command completes or aborts
//   err, timeout         sticky status of the last command
//   err_cnt              mismatching read beats of the last command (saturates)
//   wb_*                 Wishbone B3 master signals
//   fsm_state            current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE with sdr_init_done
// set; cmd_valid is ignored at all other times. A Wishbone beat completes on
// a rising edge where wb_cyc_o, wb_stb_o and wb_ack_i are all high; wb_ack_i
// is ignored while wb_cyc_o is low.

module wb_burst_master #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int BL      = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [BL-1:0]     cmd_len,
    input  logic [DW-1:0]     cmd_seed,
    output logic              done,
    output logic              err,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic [2:0]        fsm_state
);

    localparam int ADDR_LSB = $clog2(DW/8);
    localparam int TW       = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(DW/8 - 1));
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    logic [2:0]    state;
    logic [BL-1:0] k;          // current beat index
    logic [BL-1:0] last_k;     // N-1; cmd_len-1 wraps 0 to 2**BL-1 naturally
    logic [AW-1:0] base;
    logic [DW-1:0] seed;
    logic [TW-1:0] wait_cnt;

    logic          active;
    logic          last_beat;
    logic          beat_ack;
    logic [AW-1:0] beat_addr;
    logic [DW-1:0] beat_dat;

    // All bus outputs decode registered state only, so they move exactly on
    // the edge after an ack and never combinationally follow wb_ack_i.
    always_comb begin
        active    = (state == S_WR) || (state == S_RD);
        last_beat = (k == last_k);
        beat_ack  = active && wb_ack_i;
        beat_addr = base + (AW'(k) << ADDR_LSB);
        beat_dat  = seed + DW'(k);

        wb_cyc_o  = active;
        wb_stb_o  = active;
        wb_we_o   = (state == S_WR);
        wb_addr_o = active ? beat_addr : '0;
        wb_dat_o  = (state == S_WR) ? beat_dat : '0;
        wb_sel_o  = active ? '1 : '0;
        wb_cti_o  = active ? (last_beat ? CTI_END : CTI_INCR) : 3'b000;

        done      = (state == S_FIN);
        cmd_ready = (state == S_IDLE) && sdr_init_done;
        fsm_state = state;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            k        <= '0;
            last_k   <= '0;
            base     <= '0;
            seed     <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
            timeout  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        base     <= cmd_addr & ALIGN_MASK;
                        last_k   <= cmd_len - BL'(1);
                        seed     <= cmd_seed;
                        k        <= '0;
                        wait_cnt <= '0;
                        err      <= 1'b0;
                        timeout  <= 1'b0;
                        err_cnt  <= '0;
                        state    <= S_WR;
                    end
                end

                S_WR: begin
                    if (beat_ack) begin
                        wait_cnt <= '0;
                        if (last_beat) begin
                            k     <= '0;
                            state <= S_GAP;
                        end else begin
                            k <= k + BL'(1);
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout <= 1'b1;
                        err     <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                // One dead cycle between the bursts so the slave sees a
                // clean cycle boundary.
                S_GAP: begin
                    wait_cnt <= '0;
                    state    <= S_RD;
                end

                S_RD: begin
                    if (beat_ack) begin
                        wait_cnt <= '0;
                        if (wb_dat_i != beat_dat) begin
                            err <= 1'b1;
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end
                        if (last_beat) begin
                            state <= S_FIN;
                        end else begin
                            k <= k + BL'(1);
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout <= 1'b1;
                        err     <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                S_FIN: begin
                    k     <= '0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone B3 bus master, driving the SDRAM controller's Wishbone slave port (wb_stb_i/wb_cyc_i/wb_cti_i side).
- Per command, it writes an incrementing data pattern as one burst, then reads the same region back as one burst and checks every word.
- Serves as the synthesizable traffic/self-check engine for controller bring-up and for regression alongside the SDRAM models.

Parameters:
- DW, 32, Wishbone data width in bits; byte address step per beat is DW/8.
- AW, 32, Wishbone address width.
- BL, 5, width of the burst-length field; 0 encodes 2**BL beats.
- TIMEOUT, 1024, maximum cycles to wait for wb_ack_i on one beat before aborting.

Ports:
- wb_clk_i  in  1  system clock; all logic is on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- sdr_init_done  in  1  SDRAM init complete; commands are accepted only when this is high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE when sdr_init_done=1.
- cmd_addr  in  AW  byte start address, DW/8-aligned (low bits ignored).
- cmd_len  in  BL  beat count; 0 means 2**BL.
- cmd_seed  in  DW  pattern seed.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky mismatch/timeout flag for the last command.
- timeout  out  1  sticky: last command aborted on TIMEOUT.
- err_cnt  out  16  mismatching read beats of the last command, saturating at 16'hFFFF.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  1 = write phase.
- wb_addr_o  out  AW  beat address.
- wb_dat_o  out  DW  write data.
- wb_sel_o  out  DW/8  byte enables, all ones.
- wb_cti_o  out  3  3'b010 = incrementing burst, 3'b111 = end of burst.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  DW  read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, beat counter k=0.
  - Reset asserted mid-burst drops wb_cyc_o/wb_stb_o at the next edge.
  - No done pulse is issued for the aborted command.
- Derived values: N = (cmd_len==0) ? 2**BL : cmd_len. The pattern word is P(k) = cmd_seed + k, mod 2**DW. The beat address is A(k) = base + k*(DW/8), wrapping mod 2**AW.
- States and transitions:
  - IDLE: when cmd_valid & cmd_ready, latch addr/N/seed; clear err, timeout and err_cnt; set k=0; go to WR.
  - WR: drive cyc=stb=we=1, addr=A(k), dat=P(k), sel all ones.
    - cti = 3'b111 when k==N-1, else 3'b010.
    - On wb_ack_i, k++. On ack of beat N-1, go to GAP with k=0.
    - Outputs change only on the edge following an ack (registered); back-to-back acks give one beat per cycle.
  - GAP: exactly one cycle with cyc=stb=we=0; go to RD.
  - RD: cyc=stb=1, we=0, addr=A(k), cti as in WR.
    - On ack, compare wb_dat_i to P(k). On mismatch, err<=1 and err_cnt++ (saturating).
    - After the ack of beat N-1, go to FIN.
  - FIN: deassert cyc/stb; done=1 for one cycle; go to IDLE. cmd_ready rises on the following cycle.
- Timeout: a per-beat wait counter clears on each ack and on entry to WR/RD.
  - When it reaches TIMEOUT with no ack: set timeout=1 and err=1, deassert cyc/stb, go to FIN.
- cmd_valid is ignored outside IDLE. err, timeout and err_cnt hold their values until the next command is accepted.
- wb_ack_i arriving while cyc=0 is ignored.
- N=1: the single beat carries cti=3'b111.
- Write phase has no data check.

Test Plan:
- Clean write/read: addr=0x100, len=4, seed=0xA5A50000, slave acks every cycle. Required response:
  - Writes 0xA5A50000..0xA5A50003 to 0x100/0x104/0x108/0x10C, with cti 010,010,010,111.
  - Then a one-cycle GAP, reads of the same addresses, done pulse, err=0, err_cnt=0.
- Init gating: sdr_init_done=0 with cmd_valid=1 -> cmd_ready=0 and no bus activity. Raise init_done -> command accepted on the next edge.
- Corrupted read: flip bit 0 of read beat 2, len=4 -> err=1, err_cnt=1, done pulses after beat 3.
- len=0: 32 beats written and read; last address = base+0x7C; cti=111 only on beat 31.
- Timeout: with TIMEOUT=16, the slave never acks during the write -> after 16 cycles cyc/stb=0, done pulses, timeout=1, err=1.
- Reset mid-read: assert wb_rst_i at read beat 1 -> the next edge shows cyc=stb=0, err_cnt=0, cmd_ready=1 once sdr_init_done=1.
